// File: rtl/spw_status_trace_pio.sv
// spw_status_trace_pio
//   Status-trace parallel input port. A WIDTH-bit status vector is
//   synchronised into the clk domain. Every change of the synchronised value
//   is logged, with a free-running timestamp, into a small history FIFO.
//   Per-bit edge capture drives a level interrupt.
//
// Ports
//   clk        : clock; all logic runs on the rising edge
//   reset_n    : asynchronous, active-low reset
//   in_port    : status vector, asynchronous to clk
//   address    : register select
//                0 sync, 1 irq_mask, 2 edge_capture, 3 timestamp,
//                4 FIFO head/pop, 5 FIFO status/control
//   chipselect : slave select; qualifies read and write
//   read       : read strobe
//   write      : write strobe
//   writedata  : write data
//   readdata   : registered read data, valid one cycle after the read strobe
//   irq        : registered level interrupt, OR(edge_capture & irq_mask)
module spw_status_trace_pio #(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 8,
  parameter int TS_WIDTH    = 16,
  parameter int EDGE_MODE   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in_port,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam int EW = WIDTH + TS_WIDTH;
  localparam logic [1:0] EM = EDGE_MODE[1:0];

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]    prev_q;
  logic [TS_WIDTH-1:0] ts_q;
  logic [WIDTH-1:0]    mask_q;
  logic [WIDTH-1:0]    edge_q, edge_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       level_q, level_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         readdata_q, readdata_d;
  logic                irq_q;
  logic [EW-1:0]       mem_q [DEPTH];

  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] edge_set_s;
  logic [WIDTH-1:0] w1c_s;
  logic             change_s;
  logic             wr_en_s, rd_en_s;
  logic             flush_s, ovf_clr_s;
  logic             full_s, pop_s, push_s, drop_s;
  logic             unused_wdata_s;

  assign sync_s    = sync_q[SYNC_STAGES-1];
  assign change_s  = (sync_s != prev_q);
  assign wr_en_s   = chipselect & write;
  assign rd_en_s   = chipselect & read;
  assign flush_s   = wr_en_s && (address == 3'd5) && writedata[0];
  assign ovf_clr_s = wr_en_s && (address == 3'd5) && writedata[1];
  assign w1c_s     = (wr_en_s && (address == 3'd2)) ? writedata[WIDTH-1:0] : '0;
  assign full_s    = (level_q == LW'(DEPTH));
  assign pop_s     = rd_en_s && (address == 3'd4) && (level_q != '0);
  // A full FIFO still accepts a push when the same edge pops; flush beats push.
  assign push_s    = change_s && !flush_s && (!full_s || pop_s);
  assign drop_s    = change_s && !flush_s && full_s && !pop_s;
  assign unused_wdata_s = ^writedata;

  assign readdata = readdata_q;
  assign irq      = irq_q;

  // Synchroniser chain, previous-value register and free-running timestamp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      ts_q   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q <= sync_s;
      ts_q   <= ts_q + TS_WIDTH'(1);
    end
  end

  // Per-bit edge detect selected by EDGE_MODE; a new set beats a same-cycle clear.
  always_comb begin
    edge_set_s = '0;
    case (EM)
      2'd0:    edge_set_s = sync_s & ~prev_q;
      2'd1:    edge_set_s = ~sync_s & prev_q;
      default: edge_set_s = sync_s ^ prev_q;
    endcase
    edge_d = (edge_q & ~w1c_s) | edge_set_s;
  end

  // FIFO pointer/level and sticky overflow next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (flush_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
      else        rd_ptr_d = rd_ptr_q;
      if (push_s && !pop_s)      level_d = level_q + LW'(1);
      else if (pop_s && !push_s) level_d = level_q - LW'(1);
      else                       level_d = level_q;
    end
    if (drop_s)         ovf_d = 1'b1;
    else if (ovf_clr_s) ovf_d = 1'b0;
    else                ovf_d = ovf_q;
  end

  // Read data mux; an empty FIFO head reads as all zeros.
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      3'd0: readdata_d[WIDTH-1:0]    = sync_s;
      3'd1: readdata_d[WIDTH-1:0]    = mask_q;
      3'd2: readdata_d[WIDTH-1:0]    = edge_q;
      3'd3: readdata_d[TS_WIDTH-1:0] = ts_q;
      3'd4: begin
        if (level_q != '0) begin
          readdata_d[EW-1:0] = mem_q[rd_ptr_q];
          readdata_d[31]     = 1'b1;
        end else begin
          readdata_d = 32'd0;
        end
      end
      3'd5: begin
        readdata_d[LW-1:0] = level_q;
        readdata_d[31]     = ovf_q;
      end
      default: readdata_d = 32'd0;
    endcase
  end

  // Control/status registers, FIFO bookkeeping, read data and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      edge_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_en_s && (address == 3'd1)) mask_q <= writedata[WIDTH-1:0];
      edge_q   <= edge_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      if (rd_en_s) readdata_q <= readdata_d;
      irq_q    <= |(edge_q & mask_q);
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q] <= {ts_q, sync_s};
  end

endmodule

// File: doc/spw_status_trace_pio.md
SPW_STATUS_TRACE_PIO -- requirements
Module: spw_status_trace_pio

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6: number of monitored status bits, range 1..15.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2: depth of the input synchroniser chain, minimum 2.
REQ-003 The block SHALL have parameter DEPTH, default 8: number of history FIFO entries, a power of 2, minimum 2.
REQ-004 The block SHALL have parameter TS_WIDTH, default 16: timestamp width, with WIDTH+TS_WIDTH <= 31.
REQ-005 The block SHALL have parameter EDGE_MODE, default 2: edge-capture trigger, 0 = rising, 1 = falling, 2 = any change.
REQ-006 The block SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port in_port, input, WIDTH bits: status vector, asynchronous to clk.
REQ-009 The block SHALL have port address, input, 3 bits: register select.
REQ-010 The block SHALL have port chipselect, input, 1 bit: slave select.
REQ-011 The block SHALL have port read, input, 1 bit: read strobe, qualified by chipselect.
REQ-012 The block SHALL have port write, input, 1 bit: write strobe, qualified by chipselect.
REQ-013 The block SHALL have port writedata, input, 32 bits: write data.
REQ-014 The block SHALL have port readdata, output, 32 bits: registered read data.
REQ-015 The block SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-016 in_port SHALL pass through a SYNC_STAGES flip-flop chain; its output is "sync", and "prev" is sync delayed by one cycle.
REQ-017 A change event SHALL occur in any cycle where sync != prev.
REQ-018 A free-running TS_WIDTH-bit counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-019 On a change event the block SHALL push {timestamp, sync} into the FIFO; in each entry the value occupies bits [WIDTH-1:0] and the timestamp occupies [WIDTH+TS_WIDTH-1:WIDTH].
REQ-020 For each bit i, edge_capture[i] SHALL set per EDGE_MODE on that bit's sync/prev transition, and SHALL stay set until cleared.
REQ-021 irq SHALL be registered, and SHALL equal OR(edge_capture & irq_mask) of the previous cycle.
REQ-022 Address map (reads): 0 = sync zero-extended; 1 = irq_mask; 2 = edge_capture; 3 = timestamp counter; 4 = FIFO head with bit31 = valid; 5 = {overflow at bit31, level at [log2(DEPTH):0]}; 6 and 7 = 0.
REQ-023 Writes: 1 loads irq_mask[WIDTH-1:0]; 2 clears edge_capture bits where writedata = 1 (write-1-to-clear); 5 with bit0 = 1 flushes the FIFO and with bit1 = 1 clears overflow; all other write addresses SHALL be ignored.
REQ-024 readdata SHALL update only on a cycle with chipselect&read and SHALL be valid the following cycle (latency 1); otherwise it holds.
REQ-025 A read of address 4 with FIFO non-empty SHALL return the head entry with bit31 = 1 and pop it on the same edge.
REQ-026 A read of address 4 with FIFO empty SHALL return 0 and SHALL NOT pop.
REQ-027 A push while full with no simultaneous pop SHALL drop the new entry and set sticky overflow.
REQ-028 Simultaneous push and pop when full SHALL succeed for both, leave level unchanged, and leave overflow unchanged.
REQ-029 Simultaneous push and pop when empty SHALL return empty data (valid = 0) and store the pushed entry (level becomes 1).
REQ-030 An edge_capture set and a write-1-clear of the same bit in the same cycle: the set SHALL win.
REQ-031 A flush coinciding with a push SHALL leave the FIFO empty; the flush wins.
REQ-032 The FIFO SHALL preserve order, read pointer and write pointer SHALL wrap modulo DEPTH, and level SHALL range 0..DEPTH.

Reset
REQ-033 Asserting reset_n low SHALL immediately clear the sync chain, prev, timestamp, irq_mask, edge_capture, FIFO pointers and level, overflow, readdata and irq to 0, including mid-transaction; entry storage need not be cleared.
REQ-034 After release, a nonzero in_port SHALL produce a normal change event once it reaches sync.

Verification
REQ-035 Reset release with in_port = 6'h00, then in_port = 6'h15: exactly 1 FIFO entry; a read of address 4 returns bit31 = 1 and value 0x15; the timestamp equals the cycle at which sync changed.
REQ-036 EDGE_MODE = 2, irq_mask = 0x01, bit0 toggles 0->1: edge_capture = 0x01 and irq = 1; write 0x01 to address 2: irq = 0 one cycle later.
REQ-037 Nine changes with DEPTH = 8 and no reads: level = 8, overflow = 1; eight reads return the first 8 values in order; a ninth read returns 0.
REQ-038 FIFO full, read of address 4 in the same cycle as a change: level stays 8, overflow stays 0, and the newest entry appears last.
REQ-039 Write-1-clear of bit0 coincident with a new bit0 edge: edge_capture[0] stays 1.
REQ-040 reset_n pulsed low between chipselect&read and data return: readdata = 0, level = 0, irq = 0.
